// File: rtl/mem_dump_seq_if.sv
// Handshake bundle between the dump sequencer, its SRAM read port and the
// downstream stream sink.
interface mem_dump_seq_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 15
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, word_count, rd_data, out_ready,
    output rd_en, rd_addr, out_data, out_valid, busy, done
  );

  modport master (
    output start, base_addr, word_count, rd_data, out_ready,
    input  rd_en, rd_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/mem_dump_seq.sv
// Streams a contiguous SRAM window through a 2-entry FIFO with valid/ready.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_WAIT  | auto-trigger delay running
//   S_READ  | issuing SRAM reads
//   S_DRAIN | all reads issued, emptying FIFO and in-flight word
module mem_dump_seq #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 15,
  parameter int TRIG_MODE  = 0,
  parameter int AUTO_DELAY = 16
) (
  input logic           clk,
  input logic           reset,
  mem_dump_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [23:0]     DLY_END  = 24'(AUTO_DELAY);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [23:0]       dly_q, dly_d;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;

  logic [ADDR_W:0]   wc_clamped;
  logic              pop, push, rd_go, drained, done;
  logic [2:0]        occ_eff;

  assign wc_clamped = (bus.word_count > FULL_CNT) ? FULL_CNT : bus.word_count;
  assign pop        = (cnt_q != 2'd0) && bus.out_ready;
  assign push       = inflight_q;
  // Occupancy seen after this cycle's pop, so a full-rate stream keeps reading.
  assign occ_eff    = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_go      = (state_q == S_READ) && (rem_q != '0) && (occ_eff < 3'd2);
  assign drained    = !inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    dly_d   = dly_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d = bus.base_addr;
          rem_d  = wc_clamped;
          if (TRIG_MODE == 1) begin
            state_d = S_WAIT;
            dly_d   = 24'd1;
          end else begin
            state_d = (wc_clamped == '0) ? S_DRAIN : S_READ;
          end
        end
      end
      S_WAIT: begin
        if (dly_q == DLY_END) state_d = (rem_q == '0) ? S_DRAIN : S_READ;
        else                  dly_d   = dly_q + 24'd1;
      end
      S_READ: begin
        if (rd_go) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      dly_q   <= dly_d;
    end
  end

  // SRAM returns data one cycle after rd_en; capture it into the FIFO then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      inflight_q <= rd_go;
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.rd_en     = rd_go;
  assign bus.rd_addr   = addr_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = fifo_q[rd_ptr_q];
  assign bus.busy      = (state_q != S_IDLE) && !done;
  assign bus.done      = done;

endmodule

// File: tb/tb_mem_dump_seq.sv
// Scoreboard bench: two sequencers (immediate and delayed trigger) against
// a behavioural SRAM; expected words/addresses queued at stimulus time.
module tb_mem_dump_seq;
  localparam int DW = 64;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  mem_dump_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  mem_dump_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  mem_dump_seq #(.DATA_W(DW), .ADDR_W(AW), .TRIG_MODE(0), .AUTO_DELAY(16))
    dut0 (.clk(clk), .reset(rst_n), .bus(bus0));
  mem_dump_seq #(.DATA_W(DW), .ADDR_W(AW), .TRIG_MODE(1), .AUTO_DELAY(10))
    dut1 (.clk(clk), .reset(rst_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [14:0] a);
    return {a, ~a, a ^ 15'h2AAA, a + 15'd7, 4'h5};
  endfunction

  always @(posedge clk) begin
    if (bus0.rd_en) bus0.rd_data <= mem_word(bus0.rd_addr);
    if (bus1.rd_en) bus1.rd_data <= mem_word(bus1.rd_addr);
  end

  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #2;
    bus0.out_ready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
    bus1.out_ready = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [63:0] exp0_q[$], exp1_q[$];
  logic [14:0] adr0_q[$], adr1_q[$];
  int xfer0 = 0, rd_cnt0 = 0, done_cnt0 = 0, occ0 = 0, max_occ0 = 0;
  int xfer1 = 0, rd_cnt1 = 0, first_rd1 = -1;
  logic [63:0] prev_data;
  bit prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      occ0       = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus0.out_valid), 64'd1);
        chk("stall_data", bus0.out_data, prev_data);
      end
      if (bus0.rd_en) begin
        rd_cnt0++;
        occ0++;
        if (adr0_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_addr0: unexpected read at %0h", bus0.rd_addr);
        end else chk("rd_addr0", 64'(bus0.rd_addr), 64'(adr0_q.pop_front()));
      end
      if (bus0.out_valid && bus0.out_ready) begin
        xfer0++;
        occ0--;
        if (exp0_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL out_data0: unexpected word %0h", bus0.out_data);
        end else chk("out_data0", bus0.out_data, exp0_q.pop_front());
      end
      if (occ0 > max_occ0) max_occ0 = occ0;
      if (bus0.done) done_cnt0++;
      prev_stall = bus0.out_valid && !bus0.out_ready;
      prev_data  = bus0.out_data;

      if (bus1.rd_en) begin
        rd_cnt1++;
        if (first_rd1 < 0) first_rd1 = cyc;
        if (adr1_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_addr1: unexpected read at %0h", bus1.rd_addr);
        end else chk("rd_addr1", 64'(bus1.rd_addr), 64'(adr1_q.pop_front()));
      end
      if (bus1.out_valid && bus1.out_ready) begin
        xfer1++;
        if (exp1_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL out_data1: unexpected word %0h", bus1.out_data);
        end else chk("out_data1", bus1.out_data, exp1_q.pop_front());
      end
    end
  end

  // Caller is positioned at a negedge; start is held for exactly one cycle.
  task automatic dump(input int which, input logic [14:0] base, input logic [15:0] wc,
                      output int start_cyc);
    int n;
    logic [14:0] a;
    n = (wc > 16'd32768) ? 32768 : int'(wc);
    for (int i = 0; i < n; i++) begin
      a = base + 15'(i);
      if (which == 0) begin exp0_q.push_back(mem_word(a)); adr0_q.push_back(a); end
      else            begin exp1_q.push_back(mem_word(a)); adr1_q.push_back(a); end
    end
    if (which == 0) begin bus0.start = 1'b1; bus0.base_addr = base; bus0.word_count = wc; end
    else            begin bus1.start = 1'b1; bus1.base_addr = base; bus1.word_count = wc; end
    start_cyc = cyc;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, output int dcyc);
    dcyc = -1;
    for (int k = 0; k < budget; k++) begin
      if ((which == 0) ? bus0.done : bus1.done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (dcyc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: bus %0d no done within %0d cycles", which, budget);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, x, r, dc;
    bus0.start = 1'b0; bus0.base_addr = '0; bus0.word_count = '0;
    bus1.start = 1'b0; bus1.base_addr = '0; bus1.word_count = '0;

    repeat (3) @(negedge clk);
    chk("rst_rd_en0", 64'(bus0.rd_en), 64'd0);
    chk("rst_valid0", 64'(bus0.out_valid), 64'd0);
    chk("rst_busy0", 64'(bus0.busy), 64'd0);
    chk("rst_done0", 64'(bus0.done), 64'd0);
    chk("rst_addr0", 64'(bus0.rd_addr), 64'd0);
    chk("rst_data0", bus0.out_data, 64'd0);
    chk("rst_busy1", 64'(bus1.busy), 64'd0);
    chk("rst_addr1", 64'(bus1.rd_addr), 64'd0);
    rst_n = 1'b1;

    // Long full-rate dump
    @(negedge clk);
    dump(0, 15'h0000, 16'd5670, s);
    chk("busy_after_start", 64'(bus0.busy), 64'd1);
    wait_done(0, 6000, d);
    chk("done_lat_5670", 64'(d - s), 64'd5672);
    chk("busy_at_done", 64'(bus0.busy), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus0.done), 64'd0);
    chk("q_empty_5670", 64'(exp0_q.size()), 64'd0);

    // Address wrap, started the cycle after done
    r = rd_cnt0;
    dump(0, 15'h7FFE, 16'd4, s);
    wait_done(0, 50, d);
    chk("done_lat_wrap", 64'(d - s), 64'd6);
    chk("rd_cnt_wrap", 64'(rd_cnt0 - r), 64'd4);

    // Random back-pressure
    @(negedge clk);
    rand_ready = 1'b1;
    x = xfer0;
    max_occ0 = 0;
    dump(0, 15'h0ABC, 16'd64, s);
    wait_done(0, 3000, d);
    rand_ready = 1'b0;
    @(negedge clk);
    chk("xfer_rand", 64'(xfer0 - x), 64'd64);
    chk("q_empty_rand", 64'(exp0_q.size()), 64'd0);
    chk("fifo_bound", 64'(max_occ0 <= 2), 64'd1);

    // Zero-length dump
    @(negedge clk);
    r = rd_cnt0;
    dump(0, 15'h0040, 16'd0, s);
    wait_done(0, 10, d);
    chk("done_lat_zero", 64'(d - s), 64'd1);
    chk("rd_cnt_zero", 64'(rd_cnt0 - r), 64'd0);

    // Oversized count clamps to whole memory
    @(negedge clk);
    x = xfer0;
    dump(0, 15'h1234, 16'h8005, s);
    wait_done(0, 33000, d);
    chk("done_lat_full", 64'(d - s), 64'd32770);
    @(negedge clk);
    chk("xfer_full", 64'(xfer0 - x), 64'd32768);
    chk("q_empty_full", 64'(exp0_q.size()), 64'd0);

    // Abort by reset at word 100 of 200
    @(negedge clk);
    x = xfer0;
    dump(0, 15'h0100, 16'd200, s);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      #1;
      if (xfer0 - x >= 100) break;
    end
    chk("reached_word100", 64'(xfer0 - x), 64'd100);
    dc = done_cnt0;
    rst_n = 1'b0;
    #1;
    chk("abort_rd_en", 64'(bus0.rd_en), 64'd0);
    chk("abort_valid", 64'(bus0.out_valid), 64'd0);
    chk("abort_busy", 64'(bus0.busy), 64'd0);
    chk("abort_data", bus0.out_data, 64'd0);
    exp0_q.delete();
    adr0_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_done", 64'(done_cnt0), 64'(dc));
    rst_n = 1'b1;
    x = xfer0;
    dump(0, 15'h0100, 16'd200, s);
    wait_done(0, 400, d);
    chk("done_lat_restart", 64'(d - s), 64'd202);
    @(negedge clk);
    chk("xfer_restart", 64'(xfer0 - x), 64'd200);

    // Delayed trigger with an ignored start during the wait
    @(negedge clk);
    first_rd1 = -1;
    r = rd_cnt1;
    dump(1, 15'h0020, 16'd3, s);
    repeat (3) @(negedge clk);
    bus1.start = 1'b1; bus1.base_addr = 15'h0500; bus1.word_count = 16'd9;
    @(negedge clk);
    bus1.start = 1'b0;
    wait_done(1, 100, d);
    chk("first_rd_delay", 64'(first_rd1 - s), 64'd11);
    chk("done_lat_delay", 64'(d - s), 64'd15);
    chk("rd_cnt_delay", 64'(rd_cnt1 - r), 64'd3);
    @(negedge clk);
    chk("q_empty_delay", 64'(exp1_q.size()), 64'd0);

    // Delayed trigger, zero length
    @(negedge clk);
    r = rd_cnt1;
    dump(1, 15'h0077, 16'd0, s);
    wait_done(1, 50, d);
    chk("done_lat_delay_zero", 64'(d - s), 64'd11);
    chk("rd_cnt_delay_zero", 64'(rd_cnt1 - r), 64'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
